// File: rtl/count_display_driver.sv
// Display stage for the traffic-light controller: serial binary-to-BCD conversion,
// two-digit multiplexed seven-segment drive and encoded lamp-colour status.
module count_display_driver #(
    parameter int unsigned pSCAN_DIV  = 499,
    parameter int unsigned pCNT_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [pCNT_WIDTH-1:0] count,
    input  logic                  green_light,
    input  logic                  yellow_light,
    input  logic                  red_light,
    output logic [6:0]            seg,
    output logic [1:0]            dig_sel,
    output logic [1:0]            color,
    output logic                  busy
);

    localparam int unsigned SCAN_W = (pSCAN_DIV > 0) ? $clog2(pSCAN_DIV + 1) : 1;
    localparam int unsigned ITER_W = $clog2(pCNT_WIDTH + 1);
    localparam int unsigned SR_W   = 8 + pCNT_WIDTH;
    localparam int unsigned MAX_CNT = 99;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(pSCAN_DIV);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(pCNT_WIDTH - 1);
    localparam logic [6:0]        SEG_DASH  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SR_W-1:0]         sr_q;
    logic [ITER_W-1:0]       iter_q;
    logic [pCNT_WIDTH-1:0]   last_q;
    logic                    err_pend_q;
    logic                    err_q;
    logic                    valid_q;
    logic [3:0]              tens_q;
    logic [3:0]              ones_q;
    logic                    busy_q;

    logic [SCAN_W-1:0]       scan_q;
    logic                    digit_q;
    logic [1:0]              color_q;
    logic [6:0]              seg_q;
    logic [1:0]              dig_q;

    logic [SR_W-1:0]         dab_d;
    logic [SR_W-1:0]         shift_d;
    logic                    start_d;
    logic                    err_d;
    logic [1:0]              color_d;
    logic [6:0]              seg_d;
    logic [1:0]              dig_d;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1101111;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    // One double-dabble step: add 3 to BCD nibbles >= 5, then shift left.
    always_comb begin
        dab_d = sr_q;
        if (sr_q[SR_W-1 -: 4] >= 4'd5) begin
            dab_d[SR_W-1 -: 4] = sr_q[SR_W-1 -: 4] + 4'd3;
        end
        if (sr_q[SR_W-5 -: 4] >= 4'd5) begin
            dab_d[SR_W-5 -: 4] = sr_q[SR_W-5 -: 4] + 4'd3;
        end
        shift_d = {dab_d[SR_W-2:0], 1'b0};
    end

    always_comb begin
        start_d = en && (!valid_q || (count != last_q));
        err_d   = (32'(count) > 32'(MAX_CNT));
    end

    // Lamp decode: exactly one lamp lit yields its code, anything else is illegal.
    always_comb begin
        color_d = 2'b00;
        case ({green_light, yellow_light, red_light})
            3'b100:  color_d = 2'b01;
            3'b010:  color_d = 2'b10;
            3'b001:  color_d = 2'b11;
            default: color_d = 2'b00;
        endcase
    end

    always_comb begin
        seg_d = 7'b0000000;
        dig_d = 2'b00;
        if (en && valid_q) begin
            dig_d = digit_q ? 2'b10 : 2'b01;
            if (err_q || (color_d == 2'b00)) begin
                seg_d = SEG_DASH;
            end else if (digit_q) begin
                seg_d = (tens_q == 4'd0) ? 7'b0000000 : seg_pattern(tens_q);
            end else begin
                seg_d = seg_pattern(ones_q);
            end
        end
    end

    // Converter FSM; commits digits only after all shifts so the display never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            iter_q     <= '0;
            last_q     <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            busy_q     <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        sr_q       <= {8'b0, count};
                        last_q     <= count;
                        iter_q     <= '0;
                        err_pend_q <= err_d;
                        state_q    <= SHIFT;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr_q   <= shift_d;
                    iter_q <= iter_q + 1'b1;
                    busy_q <= 1'b1;
                    if (iter_q == ITER_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    tens_q  <= sr_q[SR_W-1 -: 4];
                    ones_q  <= sr_q[SR_W-5 -: 4];
                    err_q   <= err_pend_q;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Digit scan, colour register and registered segment drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q  <= '0;
            digit_q <= 1'b0;
            color_q <= 2'b00;
            seg_q   <= 7'b0000000;
            dig_q   <= 2'b00;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
            if (en) begin
                color_q <= color_d;
                if (scan_q == SCAN_LAST) begin
                    scan_q  <= '0;
                    digit_q <= ~digit_q;
                end else begin
                    scan_q <= scan_q + 1'b1;
                end
            end
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_q;
    assign color   = color_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: cycle-level reference model compared every clock,
// plus a vector table and hand-written multi-cycle sequences.
module tb_count_display_driver;

    localparam int unsigned N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [6:0] count;
    logic       g, y, r;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    logic [1:0] color;
    logic       busy;

    count_display_driver #(
        .pSCAN_DIV (N),
        .pCNT_WIDTH(7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count       (count),
        .green_light (g),
        .yellow_light(y),
        .red_light   (r),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .color       (color),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_digit(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int ref_color(input logic lg, input logic ly, input logic lr);
        if (int'(lg) + int'(ly) + int'(lr) != 1) return 0;
        if (lg) return 1;
        if (ly) return 2;
        return 3;
    endfunction

    // Reference model: abstract display state stepped once per clock edge.
    int m_t = 0, m_conv = 0, m_last = 0, m_disp = 0, m_phase = 0, m_color = 0;
    bit m_valid = 0, m_err = 0, m_started = 0;
    int e_seg = 0, e_dig = 0, e_busy = 0;

    always @(posedge clk) begin : model
        int  lamp;
        int  td;
        bit  tens_side;
        lamp = ref_color(g, y, r);
        if (rst) begin
            m_t = 0; m_conv = 0; m_last = 0; m_disp = 0; m_phase = 0; m_color = 0;
            m_valid = 0; m_err = 0;
            e_seg = 0; e_dig = 0; e_busy = 0;
        end else if (en) begin
            e_seg = 0;
            e_dig = 0;
            if (m_valid) begin
                tens_side = (m_phase > int'(N));
                e_dig = tens_side ? 2 : 1;
                td = (m_disp / 10) % 10;
                if (m_err || lamp == 0) e_seg = 7'b1000000;
                else if (tens_side) e_seg = (td == 0) ? 0 : int'(ref_digit(td));
                else e_seg = int'(ref_digit(m_disp % 10));
            end
            m_color = lamp;
            m_phase = (m_phase + 1) % (2 * (int'(N) + 1));
            if (m_t == 0) begin
                if (!m_valid || int'(count) != m_last) begin
                    m_conv = int'(count);
                    m_last = int'(count);
                    m_t = 8;
                end
            end else if (m_t == 1) begin
                m_disp = m_conv;
                m_err = (m_conv > 99);
                m_valid = 1;
                m_t = 0;
            end else begin
                m_t--;
            end
            e_busy = (m_t != 0) ? 1 : 0;
        end else begin
            e_seg = 0;
            e_dig = 0;
        end
        m_started = 1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("model_seg", int'(seg), e_seg);
            check("model_dig_sel", int'(dig_sel), e_dig);
            check("model_color", int'(color), m_color);
            check("model_busy", int'(busy), e_busy);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic [6:0] cnt;
        logic [2:0] lamps;   // {g, y, r}
        logic [6:0] ones;
        logic [6:0] tens;
        logic [1:0] col;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int got_ones, got_tens;
        logic [0:0] b[20];

        vecs[0] = '{7'd47,  3'b100, 7'b0000111, 7'b1100110, 2'b01};
        vecs[1] = '{7'd5,   3'b100, 7'b1101101, 7'b0000000, 2'b01};
        vecs[2] = '{7'd0,   3'b100, 7'b0111111, 7'b0000000, 2'b01};
        vecs[3] = '{7'd120, 3'b100, 7'b1000000, 7'b1000000, 2'b01};
        vecs[4] = '{7'd99,  3'b011, 7'b1000000, 7'b1000000, 2'b00};
        vecs[5] = '{7'd99,  3'b001, 7'b1101111, 7'b1101111, 2'b11};
        vecs[6] = '{7'd62,  3'b010, 7'b1011011, 7'b1111101, 2'b10};
        vecs[7] = '{7'd18,  3'b001, 7'b1111111, 7'b0000110, 2'b11};

        rst = 1'b1; en = 1'b0; count = 7'd0; g = 1'b0; y = 1'b0; r = 1'b0;
        repeat (3) tick();
        check("reset_seg", int'(seg), 0);
        check("reset_dig_sel", int'(dig_sel), 0);
        check("reset_color", int'(color), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // First conversion: busy length and colour latency.
        en = 1'b1; count = 7'd47; g = 1'b1;
        tick();
        check("first_color", int'(color), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n++;
            tick();
        end
        check("busy_len", n, 8);

        // Table of steady-state displays.
        for (int v = 0; v < 8; v++) begin
            count = vecs[v].cnt;
            {g, y, r} = vecs[v].lamps;
            repeat (12) tick();
            got_ones = -1;
            got_tens = -1;
            for (int i = 0; i < 16; i++) begin
                if (dig_sel == 2'b01) got_ones = int'(seg);
                if (dig_sel == 2'b10) got_tens = int'(seg);
                tick();
            end
            check($sformatf("vec%0d_ones", v), got_ones, int'(vecs[v].ones));
            check($sformatf("vec%0d_tens", v), got_tens, int'(vecs[v].tens));
            check($sformatf("vec%0d_color", v), int'(color), int'(vecs[v].col));
        end

        // Count change three clocks into a conversion.
        count = 7'd63; g = 1'b1; y = 1'b0; r = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            b[i] = busy;
            if (i == 2) count = 7'd62;
            tick();
        end
        check("midchg_busy7", int'(b[7]), 1);
        check("midchg_busy8", int'(b[8]), 0);
        check("midchg_busy9", int'(b[9]), 1);
        check("midchg_busy16", int'(b[16]), 1);
        check("midchg_busy17", int'(b[17]), 0);

        // Enable dropped during a conversion.
        count = 7'd25;
        repeat (3) tick();
        en = 1'b0;
        tick();
        check("en0_seg", int'(seg), 0);
        check("en0_dig_sel", int'(dig_sel), 0);
        check("en0_busy", int'(busy), 1);
        repeat (3) tick();
        check("en0_busy_held", int'(busy), 1);
        en = 1'b1;
        repeat (16) tick();

        // Reset in the middle of a conversion.
        count = 7'd81;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_seg", int'(seg), 0);
        check("midrst_dig_sel", int'(dig_sel), 0);
        check("midrst_color", int'(color), 0);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_blank", int'(dig_sel), 0);
        end
        repeat (8) tick();

        // Randomized traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            count = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(100, 127))
                                                 : 7'($urandom_range(0, 99));
            if ($urandom_range(0, 4) == 0) {g, y, r} = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(0, 2))
                    0: {g, y, r} = 3'b100;
                    1: {g, y, r} = 3'b010;
                    default: {g, y, r} = 3'b001;
                endcase
            end
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            repeat ($urandom_range(1, 14)) tick();
        end
        rst = 1'b0;
        en  = 1'b1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
